rr_decoder_scheduler: RTL and testbench
=======================================

// Module: rr_decoder_scheduler
// PURPOSE
//   Round-robin scheduler sharing one 3-to-8 decoded resource among 8 requesters.
//   Grants exactly one requester at a time.
//   Drives the decoder select {A2,A1,A0} as sel[2:0] and a matching one-hot grant vector.
//   Sits between requesting masters and the decoder; enforces dead time between owners.
// PARAMETERS
//   GAP_CYCLES  1    idle cycles between a release and the next grant (legal 1..15)
//   MAX_HOLD    255  max consecutive grant cycles; used only when RR_TIMEOUT_EN is defined (legal 1..255)
// PORTS
//   Clk     in   1  system clock, rising edge
//   Reset   in   1  asynchronous, active-high reset
//   req     in   8  request vector; req[i] held high for as long as requester i wants/uses the resource
//   gnt     out  8  registered one-hot grant; all-zero when idle
//   sel     out  3  registered decoder select = index of granted requester; holds last index when idle
//   busy    out  1  high while any grant is active
// BEHAVIOUR
//   Reset (async, immediate):
//     - gnt=0, sel=0, busy=0; state=IDLE; priority pointer ptr=0; counters=0.
//   State IDLE:
//     - If req==0: stay in IDLE.
//     - Else pick the first set req bit, scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
//     - On that edge: gnt=1<<i, sel=i, busy=1; go to GRANT.
//     - Latency: req high before edge n -> gnt visible after edge n (one registered stage).
//   State GRANT (owner i):
//     - Outputs held constant while req[i]=1; the other req bits are ignored.
//     - If req[i]=0 at an edge: gnt=0, busy=0, sel keeps i, ptr=(i+1) mod 8 (3-bit wrap, 7->0); go to GAP.
//   State GAP:
//     - Outputs idle for GAP_CYCLES edges, counted by a 4-bit counter.
//     - Then go to IDLE; arbitration resumes on the following edge.
//     - req changes during GAP are sampled only once back in IDLE.
//   Simultaneous events:
//     - Owner release and new requests in the same cycle: release wins, no grant that cycle.
//     - Multiple requests in IDLE: rotating priority only, no starvation.
//       Any continuously asserted req is granted within 8 grant periods.
//   Invariants:
//     - gnt is always zero or one-hot.
//     - gnt == (busy ? (8'b1 << sel) : 8'b0).
//   Reset during GRANT or GAP: outputs drop in the same cycle (async); ptr returns to 0.
// CONFIGURATION
//   RR_TIMEOUT_EN defined:
//     - An 8-bit hold counter increments each GRANT cycle.
//     - After MAX_HOLD GRANT cycles the grant is revoked even if req[i]=1: same exit path to GAP, ptr=i+1.
//     - Revoked requester i is excluded from the next arbitration only if another req bit is set.
//       If it is the sole requester, it is re-granted after GAP.
//   RR_TIMEOUT_EN undefined:
//     - No hold counter; a grant lasts until req[i] falls; MAX_HOLD is ignored.
// TESTING
//   1) Assert Reset mid-run -> gnt=8'h00, sel=3'd0, busy=0 immediately; first grant after release goes to lowest set index.
//   2) req=8'h01 from reset -> gnt=8'h01, sel=0, busy=1 one edge later; drop req -> gnt=0 next edge; next grant no earlier than GAP_CYCLES+1 edges.
//   3) req=8'hFF, each owner releases after 3 cycles -> grant order 0,1,2,...,7,0; sel tracks index; gnt never overlaps.
//   4) After owner 2 releases (ptr=3), req=8'b0000_0101 -> grant to 0 (scan 3..7 empty, wraps to 0); after its release, grant to 2.
//   5) With RR_TIMEOUT_EN, MAX_HOLD=4, req=8'h21 held -> requester 0 revoked after 4 grant cycles; requester 5 granted next; then requester 0 again.
//   6) With RR_TIMEOUT_EN, req=8'h20 only, held -> gnt=8'h20 for 4 cycles, 0 for GAP_CYCLES+1 cycles, then 8'h20 again; repeats.

Source files
------------

// File: rtl/rr_decoder_scheduler.sv
// Round-robin scheduler: grants one of 8 requesters a shared 3-to-8 decoded resource,
// with dead time between owners. Define RR_TIMEOUT_EN to revoke grants held MAX_HOLD cycles.
module rr_decoder_scheduler #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned MAX_HOLD   = 255
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q, busy_d;

    logic [7:0] arb_req;
    logic [7:0] rot;
    logic       found;
    logic [2:0] off;
    logic [2:0] win;
    logic       owner_req;
    logic       timeout_hit;
    logic       leave_grant;

`ifdef RR_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       revoked_q, revoked_d;
    logic [7:0] others;

    // A revoked owner yields only when someone else is actually waiting.
    assign others      = req & ~(8'b1 << sel_q);
    assign arb_req     = (revoked_q && (others != 8'h00)) ? others : req;
    assign timeout_hit = (hold_q == 8'(MAX_HOLD - 1));
`else
    assign arb_req     = req;
    assign timeout_hit = 1'b0;
`endif

    assign owner_req   = req[sel_q];
    assign leave_grant = !owner_req || timeout_hit;

    // First set bit scanning upward from ptr, wrapping mod 8.
    always_comb begin
        rot   = 8'(({arb_req, arb_req}) >> ptr_q);
        found = 1'b0;
        off   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = 3'(k);
            end
        end
        win = ptr_q + off;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            ptr_q     <= 3'd0;
            gap_cnt_q <= 4'd0;
            gnt_q     <= 8'h00;
            sel_q     <= 3'd0;
            busy_q    <= 1'b0;
`ifdef RR_TIMEOUT_EN
            hold_q    <= 8'd0;
            revoked_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gap_cnt_q <= gap_cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
`ifdef RR_TIMEOUT_EN
            hold_q    <= hold_d;
            revoked_q <= revoked_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gap_cnt_d = gap_cnt_q;
`ifdef RR_TIMEOUT_EN
        hold_d    = hold_q;
        revoked_d = revoked_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
`ifdef RR_TIMEOUT_EN
                    hold_d    = 8'd0;
                    revoked_d = 1'b0;
`endif
                end
            end
            StGrant: begin
                if (leave_grant) begin
                    state_d   = StGap;
                    ptr_d     = sel_q + 3'd1;
                    gap_cnt_d = 4'd0;
`ifdef RR_TIMEOUT_EN
                    revoked_d = owner_req;
                end else begin
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
            StGap: begin
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_d   = StIdle;
                    gap_cnt_d = 4'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next registered output values; sel keeps the last owner while idle.
    always_comb begin
        gnt_d  = gnt_q;
        sel_d  = sel_q;
        busy_d = busy_q;
        if (state_q == StIdle && found) begin
            gnt_d  = 8'b1 << win;
            sel_d  = win;
            busy_d = 1'b1;
        end else if (state_q == StGrant && leave_grant) begin
            gnt_d  = 8'h00;
            busy_d = 1'b0;
        end else if (state_q != StGrant) begin
            gnt_d  = 8'h00;
            busy_d = 1'b0;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_rr_decoder_scheduler.sv
// Randomized and directed bench for rr_decoder_scheduler against a transaction-level model.
// Honours RR_TIMEOUT_EN the same way the design does.
module tb_rr_decoder_scheduler;

    localparam int GAP  = 2;
    localparam int HOLD = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;

    int checks = 0;
    int failures = 0;

    rr_decoder_scheduler #(
        .GAP_CYCLES(GAP),
        .MAX_HOLD  (HOLD)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    always #5 Clk = ~Clk;

    // Model: who owns the resource, how long it has, how much dead time remains.
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_gap_left;
    int m_held;
    bit m_revoked;

    int obs[$];
    bit prev_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_sel      = 0;
        m_ptr      = 0;
        m_gap_left = 0;
        m_held     = 0;
        m_revoked  = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r);
        logic [7:0] cand;
        bit         rel;
        bit         revoke;
        int         idx;
        if (m_owner >= 0) begin
            rel    = !r[m_owner];
            revoke = 1'b0;
`ifdef RR_TIMEOUT_EN
            revoke = !rel && (m_held >= HOLD);
`endif
            if (rel || revoke) begin
                m_ptr      = (m_owner + 1) % 8;
                m_revoked  = revoke;
                m_owner    = -1;
                m_gap_left = GAP;
            end else begin
                m_held++;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else begin
            cand = r;
            if (m_revoked && ((r & ~(8'b1 << m_sel)) != 8'h00)) cand = r & ~(8'b1 << m_sel);
            for (int k = 0; k < 8; k++) begin
                idx = (m_ptr + k) % 8;
                if (m_owner < 0 && cand[idx]) begin
                    m_owner   = idx;
                    m_sel     = idx;
                    m_held    = 1;
                    m_revoked = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        logic [7:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
        check_eq("gnt", 32'(gnt), 32'(exp_gnt));
        check_eq("sel", 32'(sel), 32'(m_sel));
        check_eq("busy", 32'(busy), 32'(m_owner >= 0));
        if (busy && !prev_busy) obs.push_back(int'(sel));
        prev_busy = busy;
    endtask

    task automatic drive_cycle(input logic [7:0] r);
        @(negedge Clk);
        compare_outputs();
        req = r;
        @(posedge Clk);
        model_step(r);
    endtask

    // Reset lands between edges; outputs must clear before the next edge.
    task automatic do_reset();
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1;
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_sel", 32'(sel), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        model_reset();
        req = 8'h00;
        obs.delete();
        prev_busy = 1'b0;
        #2 Reset = 1'b0;
        @(posedge Clk);
        model_step(req);
    endtask

    task automatic check_order(input string tag, input int n, input logic [63:0] seq);
        check_eq({tag, "_count"}, 32'(obs.size() >= n), 32'h1);
        for (int k = 0; k < n; k++) begin
            check_eq(tag, (k < obs.size()) ? 32'(obs[k]) : 32'hFF, 32'(seq[4*k +: 4]));
        end
    endtask

    initial begin
        logic [7:0] r;
        int         cnt;
        model_reset();
        prev_busy = 1'b0;

        // Single requester: latency, release, dead time.
        do_reset();
        for (int i = 0; i < 4; i++) drive_cycle(8'h01);
        for (int i = 0; i < 4; i++) drive_cycle(8'h00);
        for (int i = 0; i < 6; i++) drive_cycle(8'h01);
        drive_cycle(8'h00);
        check_order("single", 2, 64'h00);

        // All requesting, each owner releases after 3 visible cycles.
        do_reset();
        cnt = 0;
        for (int c = 0; c < 200 && obs.size() < 9; c++) begin
            @(negedge Clk);
            compare_outputs();
            r = 8'hFF;
            if (busy) begin
                cnt++;
                if (cnt == 3) begin
                    r   = 8'hFF & ~(8'b1 << sel);
                    cnt = 0;
                end
            end
            req = r;
            @(posedge Clk);
            model_step(r);
        end
        check_order("rotate", 9, 64'h0_7654_3210);

        // Wrap-around scan after owner 2 releases.
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(8'h04);
        drive_cycle(8'h00);
        for (int i = 0; i < 5; i++) drive_cycle(8'h05);
        for (int i = 0; i < 6; i++) drive_cycle(8'h04);
        for (int i = 0; i < 4; i++) drive_cycle(8'h00);
        check_order("wrap", 3, 64'h202);

`ifdef RR_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 40; i++) drive_cycle(8'h21);
        check_order("revoke", 4, 64'h5050);
        do_reset();
        for (int i = 0; i < 30; i++) drive_cycle(8'h20);
        check_order("regrant", 3, 64'h555);
`endif

        // Reset while busy, then lowest set index wins from ptr 0.
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(8'hFF);
        check_eq("busy_before_rst", 32'(busy), 32'h1);
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(8'h30);
        check_order("post_rst", 1, 64'h4);

        // Random traffic with occasional asynchronous resets.
        do_reset();
        r = 8'($urandom);
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
            end
            if (c % 300 == 299) do_reset();
            else drive_cycle(r);
        end
        drive_cycle(8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
